dynamic_output_arbiter: RTL and testbench

Per-output-port wormhole arbiter for the dynamic network node. It chooses which of up to eight input FIFOs owns this output, drives the 3-bit select of the downstream 8:1 crossbar mux, and holds that select for the whole packet. It also keeps the downstream credit count for the port. Per input, it emits one-cycle dequeue strobes and an output valid.

---
 rtl/dynamic_output_arbiter.sv | 108 ++++++++++
 tb/tb_dynamic_output_arbiter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/dynamic_output_arbiter.sv
// Output-port wormhole arbiter: round-robin packet selection, crossbar select
// hold for the whole packet, and downstream credit accounting.
module dynamic_output_arbiter #(
    parameter int LEN_WIDTH = 8,
    parameter int CREDITS   = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [7:0]             req,
    input  logic [8*LEN_WIDTH-1:0] len_in,
    input  logic [7:0]             valid,
    input  logic                   credit_return,
    output logic [2:0]             sel,
    output logic                   out_valid,
    output logic [7:0]             grant,
    output logic                   busy,
    output logic [3:0]             credit_cnt
);

    typedef enum logic {IDLE, XFER} stateType;

    localparam logic [LEN_WIDTH:0] ONE        = (LEN_WIDTH+1)'(1);
    localparam logic [3:0]         CREDIT_MAX = 4'(CREDITS);

    stateType             state, stateNext;
    logic [2:0]           ptr, ptrNext, selNext, winner, idx;
    logic                 found, transfer;
    logic [LEN_WIDTH:0]   remaining, remainingNext;
    logic [3:0]           creditNext;

    // Round-robin search starting at ptr, wrapping from input 7 back to 0.
    always_comb begin
        winner = ptr;
        found  = 1'b0;
        idx    = '0;
        for (int k = 0; k < 8; k++) begin
            idx = ptr + 3'(k);
            if (!found && req[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        transfer      = (state == XFER) && valid[sel] && (credit_cnt != 4'd0);
        out_valid     = transfer;
        grant         = transfer ? (8'b1 << sel) : 8'b0;
        stateNext     = state;
        selNext       = sel;
        ptrNext       = ptr;
        remainingNext = remaining;
        case (state)
            IDLE: begin
                if (found) begin
                    stateNext     = XFER;
                    selNext       = winner;
                    ptrNext       = winner + 3'd1;
                    remainingNext = (LEN_WIDTH+1)'(len_in[winner*LEN_WIDTH +: LEN_WIDTH]) + ONE;
                end
            end
            XFER: begin
                if (transfer) begin
                    remainingNext = remaining - ONE;
                    if (remaining == ONE)
                        stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // A return and a transfer in the same cycle cancel; returns saturate at the buffer depth.
    always_comb begin
        creditNext = credit_cnt;
        if (credit_return && !transfer)
            creditNext = (credit_cnt == CREDIT_MAX) ? credit_cnt : credit_cnt + 4'd1;
        else if (transfer && !credit_return)
            creditNext = credit_cnt - 4'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            sel        <= 3'd0;
            ptr        <= 3'd0;
            remaining  <= '0;
            credit_cnt <= CREDIT_MAX;
        end else begin
            state      <= stateNext;
            sel        <= selNext;
            ptr        <= ptrNext;
            remaining  <= remainingNext;
            credit_cnt <= creditNext;
        end
    end

    assign busy = (state == XFER);

`ifndef SYNTHESIS
    // Downstream returned a credit it was never given.
    always_ff @(posedge clk) begin
        assert (reset || !(credit_return && !transfer && credit_cnt == CREDIT_MAX))
            else $error("credit_return while credit counter already full");
    end
`endif

endmodule

// File: tb/tb_dynamic_output_arbiter.sv
// Directed testbench for dynamic_output_arbiter with CREDITS=4, LEN_WIDTH=8.
module tb_dynamic_output_arbiter;

    logic        clk;
    logic        reset;
    logic [7:0]  req;
    logic [63:0] len_in;
    logic [7:0]  valid;
    logic        credit_return;
    logic [2:0]  sel;
    logic        out_valid;
    logic [7:0]  grant;
    logic        busy;
    logic [3:0]  credit_cnt;

    int checks;
    int failures;

    dynamic_output_arbiter #(.LEN_WIDTH(8), .CREDITS(4)) dut (
        .clk(clk), .reset(reset), .req(req), .len_in(len_in), .valid(valid),
        .credit_return(credit_return), .sel(sel), .out_valid(out_valid),
        .grant(grant), .busy(busy), .credit_cnt(credit_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; req = 8'h00; valid = 8'h00; credit_return = 1'b0; len_in = '0;
        tick();
        reset = 1'b0;
    endtask

    task automatic set_len(input int i, input logic [7:0] l);
        len_in[i*8 +: 8] = l;
    endtask

    task automatic test_reset();
        reset = 1'b1; req = 8'h00; valid = 8'hFF; credit_return = 1'b0; len_in = '0;
        tick();
        tick();
        #1;
        checks++; if (sel !== 3'd0) begin failures++; $display("[TB] FAIL reset_sel got=%0d exp=0", sel); end
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (grant !== 8'h00) begin failures++; $display("[TB] FAIL reset_grant got=%h exp=00", grant); end
        checks++; if (credit_cnt !== 4'd4) begin failures++; $display("[TB] FAIL reset_credit got=%0d exp=4", credit_cnt); end
        reset = 1'b0;
    endtask

    task automatic test_single_packet();
        do_reset();
        req = 8'h08; set_len(3, 8'd2); valid = 8'h08;
        #1;
        checks++; if (grant !== 8'h00) begin failures++; $display("[TB] FAIL single_idle_grant got=%h exp=00", grant); end
        tick();
        req = 8'h00;
        for (int c = 1; c <= 3; c++) begin
            #1;
            checks++; if (sel !== 3'd3) begin failures++; $display("[TB] FAIL single_sel c%0d got=%0d exp=3", c, sel); end
            checks++; if (grant !== 8'h08) begin failures++; $display("[TB] FAIL single_grant c%0d got=%h exp=08", c, grant); end
            checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL single_busy c%0d got=%b exp=1", c, busy); end
            tick();
        end
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL single_end_busy got=%b exp=0", busy); end
        checks++; if (grant !== 8'h00) begin failures++; $display("[TB] FAIL single_end_grant got=%h exp=00", grant); end
        checks++; if (credit_cnt !== 4'd1) begin failures++; $display("[TB] FAIL single_end_credit got=%0d exp=1", credit_cnt); end
        checks++; if (sel !== 3'd3) begin failures++; $display("[TB] FAIL single_sel_hold got=%0d exp=3", sel); end
    endtask

    task automatic test_round_robin();
        logic [7:0] expG [9];
        logic [2:0] expS [9];
        expG = '{8'h00, 8'h01, 8'h00, 8'h80, 8'h00, 8'h01, 8'h00, 8'h80, 8'h00};
        expS = '{3'd0, 3'd0, 3'd0, 3'd7, 3'd7, 3'd0, 3'd0, 3'd7, 3'd7};
        do_reset();
        req = 8'h81; valid = 8'hFF;
        for (int c = 0; c < 9; c++) begin
            credit_return = (c >= 2) && (c % 2 == 0);
            #1;
            checks++; if (grant !== expG[c]) begin failures++; $display("[TB] FAIL rr_grant c%0d got=%h exp=%h", c, grant, expG[c]); end
            checks++; if (sel !== expS[c]) begin failures++; $display("[TB] FAIL rr_sel c%0d got=%0d exp=%0d", c, sel, expS[c]); end
            checks++; if (busy !== (expG[c] != 8'h00)) begin failures++; $display("[TB] FAIL rr_busy c%0d got=%b exp=%b", c, busy, expG[c] != 8'h00); end
            tick();
        end
        credit_return = 1'b0; req = 8'h00;
    endtask

    task automatic test_credit_stall();
        logic [11:0] ovMask;
        logic [11:0] busyMask;
        logic [3:0]  expCnt [12];
        ovMask   = 12'h51E;
        busyMask = 12'h7FE;
        expCnt   = '{4'd4, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0, 4'd0, 4'd0, 4'd1, 4'd0, 4'd1, 4'd0};
        do_reset();
        req = 8'h20; set_len(5, 8'd5); valid = 8'h20;
        for (int c = 0; c < 12; c++) begin
            if (c == 1) req = 8'h00;
            credit_return = (c == 7) || (c == 9);
            #1;
            checks++; if (out_valid !== ovMask[c]) begin failures++; $display("[TB] FAIL stall_out_valid c%0d got=%b exp=%b", c, out_valid, ovMask[c]); end
            checks++; if (credit_cnt !== expCnt[c]) begin failures++; $display("[TB] FAIL stall_credit c%0d got=%0d exp=%0d", c, credit_cnt, expCnt[c]); end
            checks++; if (busy !== busyMask[c]) begin failures++; $display("[TB] FAIL stall_busy c%0d got=%b exp=%b", c, busy, busyMask[c]); end
            tick();
        end
        credit_return = 1'b0;
    endtask

    task automatic test_simultaneous_credit();
        logic [8:0] ovMask;
        logic [8:0] busyMask;
        logic [3:0] expCnt [9];
        ovMask   = 9'h0BE;
        busyMask = 9'h0FE;
        expCnt   = '{4'd4, 4'd4, 4'd3, 4'd2, 4'd1, 4'd1, 4'd0, 4'd1, 4'd0};
        do_reset();
        req = 8'h04; set_len(2, 8'd5); valid = 8'h04;
        for (int c = 0; c < 9; c++) begin
            if (c == 1) req = 8'h00;
            credit_return = (c == 4) || (c == 6);
            #1;
            checks++; if (out_valid !== ovMask[c]) begin failures++; $display("[TB] FAIL simul_out_valid c%0d got=%b exp=%b", c, out_valid, ovMask[c]); end
            checks++; if (credit_cnt !== expCnt[c]) begin failures++; $display("[TB] FAIL simul_credit c%0d got=%0d exp=%0d", c, credit_cnt, expCnt[c]); end
            checks++; if (busy !== busyMask[c]) begin failures++; $display("[TB] FAIL simul_busy c%0d got=%b exp=%b", c, busy, busyMask[c]); end
            if (ovMask[c]) begin
                checks++; if (grant !== 8'h04) begin failures++; $display("[TB] FAIL simul_grant c%0d got=%h exp=04", c, grant); end
            end
            tick();
        end
        credit_return = 1'b0;
    endtask

    task automatic test_valid_bubble();
        logic [7:0] ovMask;
        logic [7:0] busyMask;
        int         flits;
        ovMask   = 8'h66;
        busyMask = 8'h7E;
        flits    = 0;
        do_reset();
        req = 8'h02; set_len(1, 8'd3); valid = 8'h02;
        for (int c = 0; c < 8; c++) begin
            if (c == 1) req = 8'h00;
            valid = (c == 3 || c == 4) ? 8'hFD : 8'h02;
            #1;
            if (out_valid === 1'b1 && grant === 8'h02) flits++;
            checks++; if (out_valid !== ovMask[c]) begin failures++; $display("[TB] FAIL bubble_out_valid c%0d got=%b exp=%b", c, out_valid, ovMask[c]); end
            checks++; if (busy !== busyMask[c]) begin failures++; $display("[TB] FAIL bubble_busy c%0d got=%b exp=%b", c, busy, busyMask[c]); end
            tick();
        end
        checks++; if (flits !== 4) begin failures++; $display("[TB] FAIL bubble_flit_count got=%0d exp=4", flits); end
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        req = 8'h10; set_len(4, 8'd4); valid = 8'hFF;
        tick();
        req = 8'h00;
        #1;
        checks++; if (grant !== 8'h10) begin failures++; $display("[TB] FAIL midrst_grant_c1 got=%h exp=10", grant); end
        tick();
        reset = 1'b1;
        #1;
        checks++; if (grant !== 8'h10) begin failures++; $display("[TB] FAIL midrst_grant_c2 got=%h exp=10", grant); end
        tick();
        reset = 1'b0; req = 8'hFF;
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL midrst_busy got=%b exp=0", busy); end
        checks++; if (sel !== 3'd0) begin failures++; $display("[TB] FAIL midrst_sel got=%0d exp=0", sel); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL midrst_out_valid got=%b exp=0", out_valid); end
        checks++; if (credit_cnt !== 4'd4) begin failures++; $display("[TB] FAIL midrst_credit got=%0d exp=4", credit_cnt); end
        tick();
        req = 8'h00;
        #1;
        checks++; if (sel !== 3'd0) begin failures++; $display("[TB] FAIL midrst_rearb_sel got=%0d exp=0", sel); end
        checks++; if (grant !== 8'h01) begin failures++; $display("[TB] FAIL midrst_rearb_grant got=%h exp=01", grant); end
    endtask

    task automatic test_max_length();
        int flits;
        flits = 0;
        do_reset();
        req = 8'h40; set_len(6, 8'hFF); valid = 8'h40;
        tick();
        req = 8'h00;
        for (int c = 1; c <= 256; c++) begin
            credit_return = (c >= 2);
            #1;
            if (busy === 1'b1 && out_valid === 1'b1 && grant === 8'h40 && sel === 3'd6) flits++;
            tick();
        end
        credit_return = 1'b1;
        #1;
        checks++; if (flits !== 256) begin failures++; $display("[TB] FAIL maxlen_flit_count got=%0d exp=256", flits); end
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL maxlen_end_busy got=%b exp=0", busy); end
        checks++; if (credit_cnt !== 4'd3) begin failures++; $display("[TB] FAIL maxlen_credit got=%0d exp=3", credit_cnt); end
        tick();
        credit_return = 1'b0;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        reset = 1'b1; req = 8'h00; valid = 8'h00; credit_return = 1'b0; len_in = '0;
        test_reset();
        test_single_packet();
        test_round_robin();
        test_credit_stall();
        test_simultaneous_credit();
        test_valid_bubble();
        test_reset_mid_packet();
        test_max_length();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
